// File: rtl/zube_z80_sequencer.sv
// Z80-side bus sequencer for the zube mailbox: synchronises the Z80 I/O strobes,
// decodes the port and turns each I/O cycle into one req/ack register access.
module zube_z80_sequencer #(
  parameter logic [7:0] PORT_BASE   = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] z80_address_bus,
  input  logic [7:0] z80_data_bus_in,
  input  logic       z80_write_strobe_b,
  input  logic       z80_read_strobe_b,
  output logic [7:0] z80_data_bus_out,
  output logic       z80_bus_dir,
  output logic       reg_req,
  output logic       reg_we,
  output logic       reg_sel,
  output logic [7:0] reg_wdata,
  input  logic       reg_ack,
  input  logic [7:0] reg_rdata,
  output logic [7:0] coll_count
);

  typedef enum logic [2:0] {
    RELEASE  = 3'd0,
    IDLE     = 3'd1,
    WR_REQ   = 3'd2,
    RD_REQ   = 3'd3,
    RD_DRIVE = 3'd4
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] wr_sync, rd_sync, primed;
  logic       wr_s, rd_s, sync_ok;
  logic [7:0] offset;
  logic       addr_hit;

  logic       req_next, we_next, sel_next, dir_next, coll_inc;
  logic [7:0] wdata_next, dout_next;

  // Strobe synchronisers. The flops reset to "deasserted", so the output is only a
  // real sample once every stage has been clocked; primed tracks exactly that, which
  // keeps a strobe held low through reset from looking like a fresh release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_sync <= '1;
      rd_sync <= '1;
      primed  <= '0;
    end else begin
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], z80_write_strobe_b};
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], z80_read_strobe_b};
      primed  <= {primed[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign wr_s    = ~wr_sync[SYNC_STAGES-1];
  assign rd_s    = ~rd_sync[SYNC_STAGES-1];
  assign sync_ok = primed[SYNC_STAGES-1];

  assign offset   = z80_address_bus - PORT_BASE;
  assign addr_hit = (offset <= 8'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RELEASE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_next   = reg_req;
    we_next    = reg_we;
    sel_next   = reg_sel;
    wdata_next = reg_wdata;
    dout_next  = z80_data_bus_out;
    dir_next   = z80_bus_dir;
    coll_inc   = 1'b0;
    case (state)
      RELEASE: begin
        if (sync_ok && !wr_s && !rd_s) state_next = IDLE;
      end
      IDLE: begin
        if (wr_s && rd_s) begin
          coll_inc   = 1'b1;
          state_next = RELEASE;
        end else if (wr_s) begin
          if (addr_hit) begin
            req_next   = 1'b1;
            we_next    = 1'b1;
            sel_next   = offset[0];
            wdata_next = z80_data_bus_in;
            state_next = WR_REQ;
          end else begin
            state_next = RELEASE;
          end
        end else if (rd_s) begin
          if (addr_hit) begin
            req_next   = 1'b1;
            we_next    = 1'b0;
            sel_next   = offset[0];
            state_next = RD_REQ;
          end else begin
            state_next = RELEASE;
          end
        end
      end
      WR_REQ: begin
        if (reg_ack) begin
          req_next   = 1'b0;
          state_next = RELEASE;
        end
      end
      RD_REQ: begin
        if (reg_ack) begin
          req_next   = 1'b0;
          dout_next  = reg_rdata;
          dir_next   = 1'b1;
          state_next = RD_DRIVE;
        end
      end
      RD_DRIVE: begin
        // A write strobe while we still drive the bus is a collision
        if (wr_s) begin
          dir_next   = 1'b0;
          coll_inc   = 1'b1;
          state_next = RELEASE;
        end else if (!rd_s) begin
          dir_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        req_next   = 1'b0;
        dir_next   = 1'b0;
        state_next = RELEASE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_req          <= 1'b0;
      reg_we           <= 1'b0;
      reg_sel          <= 1'b0;
      reg_wdata        <= 8'h00;
      z80_data_bus_out <= 8'h00;
      z80_bus_dir      <= 1'b0;
      coll_count       <= 8'h00;
    end else begin
      reg_req          <= req_next;
      reg_we           <= we_next;
      reg_sel          <= sel_next;
      reg_wdata        <= wdata_next;
      z80_data_bus_out <= dout_next;
      z80_bus_dir      <= dir_next;
      if (coll_inc && coll_count != 8'hFF) coll_count <= coll_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_zube_z80_sequencer.sv
// Bench for zube_z80_sequencer: directed cases plus randomized Z80 I/O cycles
// checked against a transaction-level model of the expected register accesses.
module tb_zube_z80_sequencer;

  localparam logic [7:0] BASE = 8'h00;
  localparam int         SYNC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] addr = 8'h00;
  logic [7:0] din = 8'h00;
  logic       wr_b = 1'b1;
  logic       rd_b = 1'b1;
  logic [7:0] dout;
  logic       dir;
  logic       req;
  logic       we;
  logic       sel;
  logic [7:0] wdata;
  logic       ack = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic [7:0] coll;

  zube_z80_sequencer #(.PORT_BASE(BASE), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset),
    .z80_address_bus(addr), .z80_data_bus_in(din),
    .z80_write_strobe_b(wr_b), .z80_read_strobe_b(rd_b),
    .z80_data_bus_out(dout), .z80_bus_dir(dir),
    .reg_req(req), .reg_we(we), .reg_sel(sel), .reg_wdata(wdata),
    .reg_ack(ack), .reg_rdata(rdata), .coll_count(coll)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int req_count = 0;
  int req_cycles = 0;
  int dir_cycles = 0;
  logic req_prev = 1'b0;
  logic [9:0] req_q[$];
  int ack_delay = 0;
  logic [7:0] rd_value = 8'h00;
  bit ack_en = 1'b1;
  int exp_coll = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Bus observer: every rising reg_req is one access, recorded with its fields
  always @(negedge clk) begin
    if (req) req_cycles++;
    if (req && !req_prev) begin
      req_count++;
      req_q.push_back({we, sel, wdata});
    end
    req_prev = req;
    if (dir) dir_cycles++;
  end

  // Register-file responder: acks ack_delay cycles after seeing a request
  initial begin
    forever begin
      @(negedge clk);
      if (ack_en && req && !ack) begin
        repeat (ack_delay) @(negedge clk);
        rdata = rd_value;
        ack   = 1'b1;
        @(negedge clk);
        ack   = 1'b0;
        rdata = ~rd_value;
      end
    end
  end

  // One Z80 I/O cycle; expectations come from the port map, not from the DUT
  task automatic z80_cycle(input bit is_wr, input logic [7:0] a, input logic [7:0] d,
                           input int dly, input logic [7:0] rv, input int skew);
    int n0, d0;
    logic [7:0] off;
    bit hit;
    off = a - BASE;
    hit = (off < 8'd2);
    ack_delay = dly;
    rd_value  = rv;
    n0 = req_count;
    d0 = dir_cycles;
    req_q.delete();
    @(negedge clk);
    #(skew);
    addr = a;
    din  = d;
    if (is_wr) wr_b = 1'b0;
    else       rd_b = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    addr = 8'($urandom);
    din  = 8'($urandom);
    repeat (4 + dly) @(negedge clk);
    check("txn_nreq", 32'(req_count - n0), 32'(hit));
    if (hit && req_q.size() > 0) begin
      check("txn_we", 32'(req_q[0][9]), 32'(is_wr));
      check("txn_sel", 32'(req_q[0][8]), 32'(off[0]));
      if (is_wr) check("txn_wdata", 32'(req_q[0][7:0]), 32'(d));
    end
    if (hit && !is_wr) begin
      check("txn_dir", 32'(dir), 1);
      check("txn_dout", 32'(dout), 32'(rv));
    end else begin
      check("txn_nodrive", 32'(dir_cycles - d0), 0);
    end
    wr_b = 1'b1;
    rd_b = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
    check("txn_dir_rel", 32'(dir), 0);
    check("txn_req_rel", 32'(req), 0);
    check("txn_coll", 32'(coll), 32'(exp_coll));
  endtask

  initial begin
    int n0, rc0, d0;
    logic [7:0] dsnap;
    bit is_wr;
    logic [7:0] a;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dir", 32'(dir), 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_req", 32'(req), 0);
    check("rst_we", 32'(we), 0);
    check("rst_sel", 32'(sel), 0);
    check("rst_wdata", 32'(wdata), 0);
    check("rst_coll", 32'(coll), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Data write, ack one cycle after the request
    ack_delay = 1;
    n0 = req_count; rc0 = req_cycles; d0 = dir_cycles;
    @(negedge clk);
    addr = 8'h00; din = 8'h5A; wr_b = 1'b0;
    repeat (SYNC) @(negedge clk);
    check("wr_lat_early", 32'(req), 0);
    @(negedge clk);
    check("wr_lat", 32'(req), 1);
    check("wr_we", 32'(we), 1);
    check("wr_sel", 32'(sel), 0);
    check("wr_wdata", 32'(wdata), 32'h5A);
    repeat (6) @(negedge clk);
    check("wr_nreq", 32'(req_count - n0), 1);
    check("wr_reqlen", 32'(req_cycles - rc0), 2);
    check("wr_nodrive", 32'(dir_cycles - d0), 0);
    wr_b = 1'b1;
    repeat (6) @(negedge clk);
    check("wr_single", 32'(req_count - n0), 1);

    // Status read, ack five cycles after the request
    ack_delay = 5; rd_value = 8'hA5;
    n0 = req_count; rc0 = req_cycles; req_q.delete();
    @(negedge clk);
    addr = 8'h01; rd_b = 1'b0;
    repeat (14) @(negedge clk);
    check("st_nreq", 32'(req_count - n0), 1);
    check("st_reqlen", 32'(req_cycles - rc0), 6);
    if (req_q.size() > 0) check("st_fields", 32'(req_q[0][9:8]), 32'b01);
    check("st_dir", 32'(dir), 1);
    check("st_dout", 32'(dout), 32'hA5);
    rd_b = 1'b1;
    repeat (SYNC) @(negedge clk);
    check("st_dir_hold", 32'(dir), 1);
    @(negedge clk);
    check("st_dir_rel", 32'(dir), 0);
    repeat (4) @(negedge clk);

    // Unmatched port, then a stray ack while idle
    z80_cycle(1'b0, 8'h42, 8'h00, 0, 8'h11, 0);
    ack_en = 1'b0;
    dsnap = dout;
    n0 = req_count;
    @(negedge clk);
    ack = 1'b1; rdata = 8'hFF;
    @(negedge clk);
    ack = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_req", 32'(req), 0);
    check("stray_dir", 32'(dir), 0);
    check("stray_dout", 32'(dout), 32'(dsnap));
    check("stray_nreq", 32'(req_count - n0), 0);
    ack_en = 1'b1;
    z80_cycle(1'b1, 8'h01, 8'h77, 2, 8'h00, 0);

    // Collisions, saturating at 255
    n0 = req_count;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      wr_b = 1'b0; rd_b = 1'b0;
      repeat (6) @(negedge clk);
      wr_b = 1'b1; rd_b = 1'b1;
      repeat (6) @(negedge clk);
      exp_coll = (exp_coll < 255) ? exp_coll + 1 : 255;
      if (i == 0) check("coll_first", 32'(coll), 1);
    end
    check("coll_sat", 32'(coll), 255);
    check("coll_nreq", 32'(req_count - n0), 0);

    // Randomized cycles
    for (int i = 0; i < 40; i++) begin
      is_wr = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       a = BASE;
        1:       a = BASE + 8'd1;
        2:       a = BASE - 8'd1;
        default: a = 8'($urandom);
      endcase
      z80_cycle(is_wr, a, 8'($urandom), int'($urandom_range(0, 4)),
                8'($urandom), int'($urandom_range(0, 4)));
    end

    // Reset while driving the bus, strobe kept low
    ack_delay = 0; rd_value = 8'h3C;
    @(negedge clk);
    addr = 8'h01; rd_b = 1'b0;
    for (int i = 0; i < 20 && !dir; i++) @(negedge clk);
    check("rr_reach_drive", 32'(dir), 1);
    reset = 1'b1;
    #1;
    exp_coll = 0;
    check("rr_dir", 32'(dir), 0);
    check("rr_req", 32'(req), 0);
    check("rr_coll", 32'(coll), 0);
    n0 = req_count;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rr_noreq", 32'(req_count - n0), 0);
    check("rr_nodrive", 32'(dir), 0);
    rd_b = 1'b1;
    repeat (6) @(negedge clk);
    z80_cycle(1'b0, 8'h00, 8'h00, 2, 8'hC3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
